// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate front-end and parking_system.
package parking_pkg;

   localparam int PW_W = 4;

   typedef enum logic [1:0] {
      DB_LOW      = 2'd0,
      DB_CHK_HIGH = 2'd1,
      DB_HIGH     = 2'd2,
      DB_CHK_LOW  = 2'd3
   } db_state_e;

endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchroniser followed by a four-state debounce FSM for one gate sensor.
// Level and rise pulse are registered so they change on the same edge.
module parking_debounce
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_in,
   output logic level,
   output logic rise_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;

   // synchroniser, FSM state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= DB_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         DB_LOW: begin
            if (sync2_q) begin
               state_d = DB_CHK_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         DB_CHK_HIGH: begin
            if (!sync2_q) begin
               state_d = DB_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         DB_HIGH: begin
            if (!sync2_q) begin
               state_d = DB_CHK_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         DB_CHK_LOW: begin
            if (sync2_q) begin
               state_d = DB_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = DB_LOW;
            cnt_d   = '0;
         end
      endcase
      level_d = (state_d == DB_HIGH) || (state_d == DB_CHK_LOW);
      rise_d  = (state_q == DB_CHK_HIGH) && (state_d == DB_HIGH);
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Gate sensor conditioning plus keypad password capture with consume-on-exit and timeout.
module parking_sensor_conditioner
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PW_TIMEOUT      = 1000,
   parameter int CNT_W           = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            raw_entrance,
   input  logic            raw_exit,
   input  logic [PW_W-1:0] key_data,
   input  logic            key_strobe,
   output logic            sensor_entrance,
   output logic            sensor_exit,
   output logic            entry_event,
   output logic            exit_event,
   output logic [PW_W-1:0] password,
   output logic            password_valid
);

   if ((DEBOUNCE_CYCLES < 2) || (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
   end
   if ((PW_TIMEOUT < 1) || (64'(PW_TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
      $error("PW_TIMEOUT must be >= 1 and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(PW_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_ONE  = CNT_W'(1);

   logic            ent_level_s, ent_prev_q, ent_fall_s;
   logic [PW_W-1:0] pw_q, pw_d;
   logic            valid_q, valid_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

   parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_entrance (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_entrance),
      .level      (ent_level_s),
      .rise_pulse (entry_event)
   );

   parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_exit (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_exit),
      .level      (sensor_exit),
      .rise_pulse (exit_event)
   );

   assign sensor_entrance = ent_level_s;
   assign ent_fall_s      = ent_prev_q & ~ent_level_s;

   // password hold register, timeout counter and entrance fall detector
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_prev_q <= 1'b0;
         pw_q       <= '0;
         valid_q    <= 1'b0;
         to_cnt_q   <= '0;
      end else begin
         ent_prev_q <= ent_level_s;
         pw_q       <= pw_d;
         valid_q    <= valid_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   // A fresh strobe outranks both clear causes, so a code keyed as a car leaves survives.
   always_comb begin
      pw_d     = pw_q;
      valid_d  = valid_q;
      to_cnt_d = to_cnt_q;
      if (key_strobe) begin
         pw_d     = key_data;
         valid_d  = 1'b1;
         to_cnt_d = '0;
      end else if (ent_fall_s || (valid_q && (to_cnt_q == TO_LAST))) begin
         pw_d     = '0;
         valid_d  = 1'b0;
         to_cnt_d = '0;
      end else if (valid_q) begin
         to_cnt_d = to_cnt_q + TO_ONE;
      end else begin
         to_cnt_d = to_cnt_q;
      end
   end

   assign password       = pw_q;
   assign password_valid = valid_q;

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs per clock edge,
// an independent monitor pops and compares them against the DUT.
module tb_parking_sensor_conditioner;

   localparam int DC  = 4;
   localparam int PWT = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       raw_entrance = 1'b0;
   logic       raw_exit = 1'b0;
   logic [3:0] key_data = 4'd0;
   logic       key_strobe = 1'b0;
   logic       sensor_entrance, sensor_exit, entry_event, exit_event, password_valid;
   logic [3:0] password;

   parking_sensor_conditioner #(.DEBOUNCE_CYCLES(DC), .PW_TIMEOUT(PWT), .CNT_W(16)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .raw_entrance    (raw_entrance),
      .raw_exit        (raw_exit),
      .key_data        (key_data),
      .key_strobe      (key_strobe),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .entry_event     (entry_event),
      .exit_event      (exit_event),
      .password        (password),
      .password_valid  (password_valid)
   );

   always #10 clk = ~clk;

   // {lvl_exit, lvl_ent, ev_exit, ev_ent, pw[3:0], valid}
   typedef struct {
      int unsigned edge_n;
      logic [8:0]  v;
   } sb_t;

   sb_t sb [$];
   int  checks = 0;
   int  errors = 0;

   int unsigned edge_no = 0;
   logic [1:0]  m_d1 = 2'b00, m_d2 = 2'b00, m_lvl = 2'b00, m_ev = 2'b00;
   int          m_streak [2] = '{0, 0};
   logic        m_fell = 1'b0;
   logic [3:0]  m_pw = 4'd0;
   logic        m_valid = 1'b0;
   int unsigned m_cap = 0;

   // A debounced level follows the synced input once DC consecutive samples disagree with it.
   task automatic model_edge();
      sb_t e;
      edge_no++;
      if (!reset_n) begin
         m_d1 = 2'b00; m_d2 = 2'b00; m_lvl = 2'b00; m_ev = 2'b00;
         m_streak[0] = 0; m_streak[1] = 0;
         m_fell = 1'b0; m_pw = 4'd0; m_valid = 1'b0;
      end else begin
         if (key_strobe) begin
            m_pw = key_data; m_valid = 1'b1; m_cap = edge_no;
         end else if (m_fell || (m_valid && (edge_no - m_cap == PWT))) begin
            m_pw = 4'd0; m_valid = 1'b0;
         end
         m_fell = 1'b0;
         m_ev   = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (m_d2[i] != m_lvl[i]) begin
               m_streak[i]++;
               if (m_streak[i] == DC) begin
                  m_lvl[i]    = m_d2[i];
                  m_streak[i] = 0;
                  m_ev[i]     = m_lvl[i];
                  if (i == 0 && !m_lvl[i]) m_fell = 1'b1;
               end
            end else begin
               m_streak[i] = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = {raw_exit, raw_entrance};
      end
      e.edge_n = edge_no;
      e.v      = {m_lvl, m_ev, m_pw, m_valid};
      sb.push_back(e);
   endtask

   task automatic tick(input logic rn, input logic re, input logic rx,
                       input logic ks, input logic [3:0] kd);
      @(posedge clk);
      model_edge();
      #4;
      reset_n = rn; raw_entrance = re; raw_exit = rx; key_strobe = ks; key_data = kd;
   endtask

   task automatic idle(input int n, input logic re, input logic rx);
      for (int i = 0; i < n; i++) tick(1'b1, re, rx, 1'b0, 4'd0);
   endtask

   // monitor: compare every DUT edge against the queued expectation
   initial begin
      sb_t        e;
      logic [8:0] got;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {sensor_exit, sensor_entrance, exit_event, entry_event, password, password_valid};
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL edge %0d: got lvl=%b ev=%b pw=%b valid=%b, expected lvl=%b ev=%b pw=%b valid=%b",
                        e.edge_n, got[8:7], got[6:5], got[4:1], got[0],
                        e.v[8:7], e.v[6:5], e.v[4:1], e.v[0]);
            end
         end
      end
   end

   initial begin
      int   run_e, run_x;
      logic re, rx;
      #1 reset_n = 1'b0;
      for (int i = 0; i < 8; i++)
         tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 4'd0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(8, 1'b0, 1'b0);
      // clean entrance rise and fall
      idle(10, 1'b1, 1'b0);
      idle(10, 1'b0, 1'b0);
      // bounce: 3 high, 1 low, 3 high must not qualify; then a long high does
      idle(3, 1'b1, 1'b0); idle(1, 1'b0, 1'b0); idle(3, 1'b1, 1'b0);
      idle(3, 1'b0, 1'b0); idle(7, 1'b1, 1'b0); idle(10, 1'b0, 1'b0);
      // simultaneous qualification
      idle(8, 1'b1, 1'b1);
      idle(10, 1'b0, 1'b0);
      // capture then consume by entrance passage
      tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
      idle(4, 1'b0, 1'b0);
      idle(8, 1'b1, 1'b0);
      idle(12, 1'b0, 1'b0);
      // overwrite, timeout, then strobe landing on the clear cycle
      tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b1001);
      idle(9, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
      idle(24, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b0101);
      idle(19, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b0011);
      idle(25, 1'b0, 1'b0);
      // reset mid-debounce and mid-hold
      tick(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
      idle(4, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      idle(12, 1'b1, 1'b1);
      idle(10, 1'b0, 1'b0);
      // randomized runs of varying length with strobes and rare resets
      re = 1'b0; rx = 1'b0; run_e = 0; run_x = 0;
      for (int i = 0; i < 1500; i++) begin
         if (run_e == 0) begin re = 1'($urandom_range(0, 1)); run_e = $urandom_range(1, 9); end
         if (run_x == 0) begin rx = 1'($urandom_range(0, 1)); run_x = $urandom_range(1, 9); end
         run_e--; run_x--;
         tick(($urandom_range(0, 299) != 0), re, rx, ($urandom_range(0, 11) == 0),
              4'($urandom_range(0, 15)));
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #5;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
